bitstream_bit_reader: RTL and testbench

- Parametrised successor to the byte-oriented file reader in the VVC arithmetic-decoder front end.
- Accepts a byte stream from the bitstream source through a valid/ready handshake and holds it in an MSB-first bit buffer.
- Serves variable-length bit requests to the arithmetic decoder: 9-bit ivlOffset initialisation, 1-bit renormalisation and multi-bit bypass reads.
- Adds peek (non-consuming) reads, byte-alignment, end-of-stream zero padding and a consumed-bit counter.

---
 rtl/bitstream_bit_reader_pkg.sv | 19 +
 rtl/bit_shift_buffer.sv | 51 +++++
 rtl/bitstream_bit_reader.sv | 157 +++++++++++++++
 tb/tb_bitstream_bit_reader.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bitstream_bit_reader_pkg.sv
// Shared types and elaboration helpers for the bitstream bit reader.
package bitstream_reader_pkg;

    typedef enum logic {
        IDLE,
        WAIT
    } rd_state_e;

    // Bits needed to hold the value n (0..n inclusive).
    function automatic int width_of(input int n);
        return $clog2(n + 1);
    endfunction

    // A full-size request must still leave room for one incoming word.
    function automatic bit buf_cfg_ok(input int buf_w, input int max_req, input int in_w);
        return buf_w >= max_req + in_w;
    endfunction

endpackage

// File: rtl/bit_shift_buffer.sv
// MSB-first bit buffer: consumes from the top and appends new words directly
// below the last valid bit, both in the same cycle if required.
module bit_shift_buffer
    import bitstream_reader_pkg::*;
#(
    parameter int BUF_W   = 32,
    parameter int IN_W    = 8,
    parameter int MAX_REQ = 16,
    parameter int LVL_W   = width_of(BUF_W)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [LVL_W-1:0]   shift_amt,
    input  logic               wr_en,
    input  logic [IN_W-1:0]    wr_data,
    output logic [MAX_REQ-1:0] top_bits,
    output logic [LVL_W-1:0]   level
);

    logic [BUF_W-1:0] bits_q, bits_next;
    logic [LVL_W-1:0] level_q, level_next;

    // Bits below the fill level are always zero, so shifting pulls in zeros and
    // an append is a plain OR; that same property gives end-of-stream padding.
    always_comb begin
        // NOTE: blocking assignments with a default first keep this purely
        // combinational and stop latches being inferred.
        bits_next  = bits_q << shift_amt;
        level_next = level_q - shift_amt;
        if (wr_en) begin
            bits_next  = bits_next | ({wr_data, {(BUF_W-IN_W){1'b0}}} >> level_next);
            level_next = level_next + LVL_W'(IN_W);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the buffer is reset because the zero-below-level property is
        // relied upon for padding; it is a register, not a RAM.
        if (!rst_n) begin
            bits_q  <= '0;
            level_q <= '0;
        end else begin
            bits_q  <= bits_next;
            level_q <= level_next;
        end
    end

    assign top_bits = bits_q[BUF_W-1 -: MAX_REQ];
    assign level    = level_q;

endmodule

// File: rtl/bitstream_bit_reader.sv
// Variable-length bit reader for the arithmetic decoder: reads, peeks,
// byte alignment, end-of-stream zero padding and a consumed-bit counter.
module bitstream_bit_reader
    import bitstream_reader_pkg::*;
#(
    parameter int IN_W    = 8,
    parameter int MAX_REQ = 16,
    parameter int BUF_W   = 32,
    parameter int LEN_W   = width_of(MAX_REQ),
    parameter int LVL_W   = width_of(BUF_W)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [IN_W-1:0]    in_data,
    input  logic               in_valid,
    input  logic               in_last,
    output logic               in_ready,
    input  logic               req,
    input  logic [LEN_W-1:0]   req_len,
    input  logic               req_peek,
    input  logic               req_align,
    output logic               req_ready,
    output logic [MAX_REQ-1:0] out_data,
    output logic               out_valid,
    output logic               out_eos,
    output logic [LVL_W-1:0]   level,
    output logic [31:0]        bits_consumed
);

    localparam bit CFG_OK = buf_cfg_ok(BUF_W, MAX_REQ, IN_W);

    if (!CFG_OK) begin : g_bad_cfg
        $error("bitstream_bit_reader: BUF_W must be >= MAX_REQ + IN_W");
    end

    rd_state_e          state_q;
    logic               req_ready_q;
    logic               eos_seen_q;
    logic [LEN_W-1:0]   lat_len_q;
    logic               lat_peek_q, lat_align_q;
    logic [MAX_REQ-1:0] out_data_q;
    logic               out_valid_q, out_eos_q;
    logic [31:0]        consumed_q;

    logic [MAX_REQ-1:0] top_bits;
    logic [LVL_W-1:0]   buf_level;
    logic [LVL_W-1:0]   shift_amt;
    logic               wr_en;

    logic [LEN_W-1:0]   act_len;
    logic               act_peek, act_align, active;
    logic [31:0]        word_rem;
    logic [LVL_W-1:0]   align_d, need, take;
    logic               sufficient, serve;
    logic [MAX_REQ-1:0] data_next;
    logic               eos_next;

    bit_shift_buffer #(
        .BUF_W   (BUF_W),
        .IN_W    (IN_W),
        .MAX_REQ (MAX_REQ),
        .LVL_W   (LVL_W)
    ) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .shift_amt (shift_amt),
        .wr_en     (wr_en),
        .wr_data   (in_data),
        .top_bits  (top_bits),
        .level     (buf_level)
    );

    assign in_ready = !eos_seen_q && (buf_level <= LVL_W'(BUF_W - IN_W));
    assign wr_en    = in_valid && in_ready;

    always_comb begin
        if (state_q == WAIT) begin
            act_len   = lat_len_q;
            act_peek  = lat_peek_q;
            act_align = lat_align_q;
        end else begin
            act_len   = (req_len > LEN_W'(MAX_REQ)) ? LEN_W'(MAX_REQ) : req_len;
            act_peek  = req_peek;
            act_align = req_align;
        end
        active = (state_q == WAIT) || (req && req_ready_q);

        word_rem = consumed_q % 32'(IN_W);
        align_d  = LVL_W'((32'(IN_W) - word_rem) % 32'(IN_W));
        need     = act_align ? align_d : LVL_W'(act_len);

        sufficient = (buf_level >= need) || eos_seen_q;
        serve      = active && sufficient;
        // Past end of stream only the real bits are consumed; the rest is padding.
        take       = (need > buf_level) ? buf_level : need;
        shift_amt  = (serve && (act_align || !act_peek)) ? take : '0;
        data_next  = act_align ? '0 : (top_bits >> (LEN_W'(MAX_REQ) - act_len));
        eos_next   = need > buf_level;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b0;
            eos_seen_q  <= 1'b0;
            lat_len_q   <= '0;
            lat_peek_q  <= 1'b0;
            lat_align_q <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_eos_q   <= 1'b0;
            consumed_q  <= '0;
        end else begin
            out_valid_q <= serve;
            if (serve) begin
                out_data_q <= data_next;
                out_eos_q  <= eos_next;
            end
            if (wr_en && in_last) begin
                eos_seen_q <= 1'b1;
            end
            consumed_q <= consumed_q + 32'(shift_amt);

            case (state_q)
                IDLE: begin
                    if (active && !serve) begin
                        state_q     <= WAIT;
                        req_ready_q <= 1'b0;
                        lat_len_q   <= act_len;
                        lat_peek_q  <= act_peek;
                        lat_align_q <= act_align;
                    end else begin
                        req_ready_q <= 1'b1;
                    end
                end
                WAIT: begin
                    if (serve) begin
                        state_q     <= IDLE;
                        req_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    req_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready     = req_ready_q;
    assign out_data      = out_data_q;
    assign out_valid     = out_valid_q;
    assign out_eos       = out_eos_q;
    assign level         = buf_level;
    assign bits_consumed = consumed_q;

endmodule

// File: tb/tb_bitstream_bit_reader.sv
// Scoreboard bench for bitstream_bit_reader: directed requests push expected
// responses; a monitor pops and compares on every out_valid.
module tb_bitstream_bit_reader;

    localparam int IN_W    = 8;
    localparam int MAX_REQ = 16;
    localparam int BUF_W   = 32;
    localparam int LEN_W   = 5;
    localparam int LVL_W   = 6;

    typedef struct {
        logic [MAX_REQ-1:0] data;
        logic               eos;
    } resp_t;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [IN_W-1:0]    in_data = '0;
    logic               in_valid = 1'b0;
    logic               in_last = 1'b0;
    logic               in_ready;
    logic               req = 1'b0;
    logic [LEN_W-1:0]   req_len = '0;
    logic               req_peek = 1'b0;
    logic               req_align = 1'b0;
    logic               req_ready;
    logic [MAX_REQ-1:0] out_data;
    logic               out_valid;
    logic               out_eos;
    logic [LVL_W-1:0]   level;
    logic [31:0]        bits_consumed;

    int    checks = 0;
    int    errors = 0;
    resp_t exp_q[$];

    bitstream_bit_reader #(
        .IN_W    (IN_W),
        .MAX_REQ (MAX_REQ),
        .BUF_W   (BUF_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_last       (in_last),
        .in_ready      (in_ready),
        .req           (req),
        .req_len       (req_len),
        .req_peek      (req_peek),
        .req_align     (req_align),
        .req_ready     (req_ready),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_eos       (out_eos),
        .level         (level),
        .bits_consumed (bits_consumed)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every response must match the oldest outstanding expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && out_valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out_valid", 32'(out_valid), 32'd0);
                end else begin
                    resp_t e;
                    e = exp_q.pop_front();
                    check("resp_data", 32'(out_data), 32'(e.data));
                    check("resp_eos", 32'(out_eos), 32'(e.eos));
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_level", 32'(level), 32'd0);
        check("rst_bits_consumed", bits_consumed, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic push_byte(input logic [7:0] b, input bit last);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
        in_data  = b;
        in_last  = last;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic do_req(input int len, input bit peek, input bit align,
                          input logic [15:0] ed, input bit ee, input bit expect_resp);
        int n = 0;
        resp_t r;
        @(negedge clk);
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) check("req_ready_timeout", 32'(req_ready), 32'd1);
        if (expect_resp) begin
            r.data = ed;
            r.eos  = ee;
            exp_q.push_back(r);
        end
        req       = 1'b1;
        req_len   = LEN_W'(len);
        req_peek  = peek;
        req_align = align;
        @(negedge clk);
        req       = 1'b0;
        req_peek  = 1'b0;
        req_align = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        resp_t r;
        // Reset state.
        do_reset();
        check("idle_req_ready", 32'(req_ready), 32'd1);

        // Init read: 0xA5 0x3C, 9 bits -> 1_0100_1010.
        push_byte(8'hA5, 1'b0);
        push_byte(8'h3C, 1'b0);
        do_req(9, 1'b0, 1'b0, 16'h14A, 1'b0, 1'b1);
        check("init_level", 32'(level), 32'd7);
        check("init_consumed", bits_consumed, 32'd9);
        do_req(7, 1'b0, 1'b0, 16'h3C, 1'b0, 1'b1);
        drain("init_drain");

        // Peek then read.
        do_reset();
        push_byte(8'hF0, 1'b0);
        do_req(4, 1'b1, 1'b0, 16'hF, 1'b0, 1'b1);
        check("peek_level", 32'(level), 32'd8);
        check("peek_consumed", bits_consumed, 32'd0);
        do_req(4, 1'b0, 1'b0, 16'hF, 1'b0, 1'b1);
        check("read_level", 32'(level), 32'd4);
        do_req(4, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
        drain("peek_drain");

        // Starvation: 12 bits from an empty buffer waits for two bytes.
        do_reset();
        do_req(12, 1'b0, 1'b0, 16'h123, 1'b0, 1'b1);
        check("starve_req_ready", 32'(req_ready), 32'd0);
        push_byte(8'h12, 1'b0);
        check("starve_pending", 32'(exp_q.size()), 32'd1);
        push_byte(8'h34, 1'b0);
        drain("starve_drain");
        @(negedge clk);
        check("starve_back_idle", 32'(req_ready), 32'd1);
        check("starve_level", 32'(level), 32'd4);

        // Alignment after 3 bits; a second align at a boundary discards nothing.
        do_reset();
        push_byte(8'hFF, 1'b0);
        push_byte(8'h81, 1'b0);
        do_req(3, 1'b0, 1'b0, 16'h7, 1'b0, 1'b1);
        do_req(0, 1'b1, 1'b1, 16'h0, 1'b0, 1'b1);
        check("align_consumed", bits_consumed, 32'd8);
        check("align_level", 32'(level), 32'd8);
        do_req(8, 1'b0, 1'b0, 16'h81, 1'b0, 1'b1);
        do_req(0, 1'b0, 1'b1, 16'h0, 1'b0, 1'b1);
        check("align_noop_consumed", bits_consumed, 32'd16);
        drain("align_drain");

        // End-of-stream padding.
        do_reset();
        push_byte(8'hC0, 1'b1);
        check("eos_in_ready", 32'(in_ready), 32'd0);
        do_req(4, 1'b0, 1'b0, 16'hC, 1'b0, 1'b1);
        do_req(8, 1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
        check("eos_level", 32'(level), 32'd0);
        check("eos_consumed", bits_consumed, 32'd8);
        do_req(1, 1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
        do_req(0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
        check("eos_in_ready_after", 32'(in_ready), 32'd0);
        drain("eos_drain");

        // Simultaneous consume and fill, then clamped length.
        do_reset();
        push_byte(8'hAB, 1'b0);
        push_byte(8'hCD, 1'b0);
        @(negedge clk);
        r.data = 16'hAB;
        r.eos  = 1'b0;
        exp_q.push_back(r);
        req      = 1'b1;
        req_len  = LEN_W'(8);
        in_data  = 8'hEF;
        in_valid = 1'b1;
        @(negedge clk);
        req      = 1'b0;
        in_valid = 1'b0;
        check("concurrent_level", 32'(level), 32'd16);
        do_req(16, 1'b0, 1'b0, 16'hCDEF, 1'b0, 1'b1);
        push_byte(8'h12, 1'b0);
        push_byte(8'h34, 1'b0);
        push_byte(8'h56, 1'b0);
        check("full_level", 32'(level), 32'd24);
        do_req(31, 1'b0, 1'b0, 16'h1234, 1'b0, 1'b1);
        check("clamp_level", 32'(level), 32'd8);
        check("clamp_consumed", bits_consumed, 32'd40);
        drain("concurrent_drain");

        // Reset while a request waits: it must be dropped with no response.
        do_reset();
        do_req(12, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
        check("wait_req_ready", 32'(req_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_level", 32'(level), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        push_byte(8'h12, 1'b0);
        push_byte(8'h34, 1'b0);
        repeat (4) @(negedge clk);
        check("midrst_level_after", 32'(level), 32'd16);
        check("midrst_consumed", bits_consumed, 32'd0);
        check("midrst_req_ready", 32'(req_ready), 32'd1);
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
